// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, sizes and helpers for the load/store unit.
// Optional feature macro used by the LSU: LSU_MISALIGNED_EN.
package lsu_pkg;

    localparam int unsigned LSU_WORD_BYTES = 4;
    localparam int unsigned LSU_XLEN       = 32;

    // Access size encodings, identical to the RISC-V load/store funct3 field
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lsu_state_e;

    // Access size in bytes; 0 marks an illegal funct3
    function automatic logic [2:0] ls_size_bytes(input logic [2:0] funct3);
        case (funct3)
            LS_B, LS_BU: return 3'd1;
            LS_H, LS_HU: return 3'd2;
            LS_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    // Right-justified byte-enable mask for an access of the given byte size
    function automatic logic [3:0] ls_be_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: MEM-stage request/response and data_mem bus of the load/store unit.
// Signal names are given from the LSU's point of view (i_ = into the LSU).
interface lsu_if;

    logic        i_req_valid;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_busy;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_misaligned;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic [31:0] i_mem_rdata;

    // LSU side
    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_rdata,
        output o_busy, o_rsp_valid, o_rsp_rdata, o_misaligned,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

    // Pipeline / memory side
    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_rdata,
        input  o_busy, o_rsp_valid, o_rsp_rdata, o_misaligned,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: truncates a right-justified word to the load size and
// sign- or zero-extends it according to funct3. Illegal funct3 yields 0.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    // Truncate and extend by access type
    always_comb begin
        o_data = 32'd0;
        case (i_funct3)
            LS_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            LS_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            LS_W:    o_data = i_data;
            LS_BU:   o_data = {24'd0, i_data[7:0]};
            LS_HU:   o_data = {16'd0, i_data[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit in front of data_mem. Aligned accesses are
// purely combinational; word-crossing accesses are either split into two
// memory cycles (LSU_MISALIGNED_EN defined) or flagged via o_misaligned.
module lsu
    import lsu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    lsu_if.slave bus
);

    logic [2:0]  w_size;
    logic [1:0]  w_off;
    logic        w_legal;
    logic        w_cross;
    logic [4:0]  w_off_sh;
    logic [5:0]  w_n1_sh;
    logic [31:0] w_word_a;
    logic [31:0] w_word_b;
    logic [7:0]  w_be_wide;
    logic [63:0] w_wd_wide;
    logic [31:0] w_ext_in;
    logic [31:0] w_ext_out;
    logic        w_in_second;
    logic [31:0] w_low_q;

    assign w_size    = ls_size_bytes(bus.i_req_funct3);
    assign w_legal   = (w_size != 3'd0);
    assign w_off     = bus.i_req_addr[1:0];
    assign w_cross   = w_legal && (({2'b00, w_off} + {1'b0, w_size}) > 4'd4);
    assign w_off_sh  = {w_off, 3'b000};
    assign w_n1_sh   = 6'd32 - {1'b0, w_off_sh};
    assign w_word_a  = {bus.i_req_addr[31:2], 2'b00};
    assign w_word_b  = w_word_a + 32'd4;
    // Low nibble/word serve the first (or only) access, high the second half
    assign w_be_wide = {4'b0000, ls_be_mask(w_size)} << w_off;
    assign w_wd_wide = {32'd0, bus.i_req_wdata} << w_off_sh;

    lsu_load_ext u_load_ext (
        .i_funct3 (bus.i_req_funct3),
        .i_data   (w_ext_in),
        .o_data   (w_ext_out)
    );

`ifdef LSU_MISALIGNED_EN
    lsu_state_e  r_state;
    lsu_state_e  w_state_d;
    logic [31:0] r_low;
    logic [31:0] w_low_d;

    // State and low-part register; reset also aborts a pending second access
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_low   <= 32'd0;
        end else begin
            r_state <= w_state_d;
            r_low   <= w_low_d;
        end
    end

    assign w_in_second = (r_state == SECOND);
    assign w_low_q     = r_low;
`else
    assign w_in_second = 1'b0;
    assign w_low_q     = 32'd0;
`endif

    // Next state and all bus outputs; everything is held at zero during reset
    always_comb begin
        bus.o_busy       = 1'b0;
        bus.o_rsp_valid  = 1'b0;
        bus.o_rsp_rdata  = 32'd0;
        bus.o_misaligned = 1'b0;
        bus.o_mem_we     = 1'b0;
        bus.o_mem_addr   = 32'd0;
        bus.o_mem_wdata  = 32'd0;
        bus.o_mem_be     = 4'b0000;
        w_ext_in         = 32'd0;
`ifdef LSU_MISALIGNED_EN
        w_state_d        = r_state;
        w_low_d          = r_low;
`endif
        if (!i_rst) begin
            if (w_in_second) begin
`ifdef LSU_MISALIGNED_EN
                w_state_d = IDLE;
`endif
                // A dropped valid here is a flush: no second access, no response
                if (bus.i_req_valid) begin
                    bus.o_mem_addr  = w_word_b;
                    bus.o_mem_be    = w_be_wide[7:4];
                    bus.o_mem_wdata = w_wd_wide[63:32];
                    bus.o_mem_we    = bus.i_req_we;
                    w_ext_in        = w_low_q | (bus.i_mem_rdata << w_n1_sh);
                    bus.o_rsp_valid = 1'b1;
                    bus.o_rsp_rdata = bus.i_req_we ? 32'd0 : w_ext_out;
                end
            end else if (bus.i_req_valid) begin
                if (!w_legal) begin
                    bus.o_rsp_valid = 1'b1;
                end else if (w_cross) begin
`ifdef LSU_MISALIGNED_EN
                    bus.o_mem_addr  = w_word_a;
                    bus.o_mem_be    = w_be_wide[3:0];
                    bus.o_mem_wdata = w_wd_wide[31:0];
                    bus.o_mem_we    = bus.i_req_we;
                    bus.o_busy      = 1'b1;
                    if (!bus.i_req_we) begin
                        w_low_d = bus.i_mem_rdata >> w_off_sh;
                    end
                    w_state_d = SECOND;
`else
                    bus.o_misaligned = 1'b1;
`endif
                end else begin
                    bus.o_mem_addr  = w_word_a;
                    bus.o_mem_be    = w_be_wide[3:0];
                    bus.o_mem_wdata = w_wd_wide[31:0];
                    bus.o_mem_we    = bus.i_req_we;
                    w_ext_in        = bus.i_mem_rdata >> w_off_sh;
                    bus.o_rsp_valid = 1'b1;
                    bus.o_rsp_rdata = bus.i_req_we ? 32'd0 : w_ext_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a small byte-enabled
// data memory model (asynchronous read, write on clock edge).
// Split-access checks are built when LSU_MISALIGNED_EN is defined,
// misaligned-exception checks otherwise.
module tb_lsu;

    logic clk;
    logic rst;
    logic mem_clr;
    int   n_vec;
    int   n_err;

    lsu_if bus ();

    lsu dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // {busy, rsp_valid, misaligned, mem_we}
    logic [3:0] ctrl;
    assign ctrl = {bus.o_busy, bus.o_rsp_valid, bus.o_misaligned, bus.o_mem_we};

    logic [31:0] mem [0:63];
    assign bus.i_mem_rdata = mem[bus.o_mem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: cleared only by mem_clr so DUT resets keep stored data
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (bus.o_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_mem_be[b]) mem[bus.o_mem_addr[7:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.i_req_valid  = v;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = a;
        bus.i_req_wdata  = wd;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_clr = 1'b1;
        drive(1'b1, 1'b1, 3'b010, 32'h0000_0011, 32'hFFFF_FFFF);
        n_vec++;
        if (ctrl !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 4'b0000);
        end
        n_vec++;
        if ({bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata, bus.o_rsp_rdata} !== 100'd0) begin
            n_err++;
            $display("FAIL reset_bus be %b addr %h wd %h rd %h exp all zero",
                     bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata, bus.o_rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== 8'h00) begin
            n_err++; $display("FAIL post_reset_idle got %b exp %b", {ctrl, bus.o_mem_be}, 8'h00);
        end
        @(negedge clk);
    endtask

    task automatic test_word;
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_mem_addr} !== {4'b0101, 4'b1111, 32'h10}) begin
            n_err++; $display("FAIL sw_ctrl got %b %b %h exp 0101 1111 00000010",
                              ctrl, bus.o_mem_be, bus.o_mem_addr);
        end
        n_vec++;
        if ({bus.o_mem_wdata, bus.o_rsp_rdata} !== {32'hDEAD_BEEF, 32'h0}) begin
            n_err++; $display("FAIL sw_data got wd %h rd %h exp deadbeef 0",
                              bus.o_mem_wdata, bus.o_rsp_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_rsp_rdata} !== {4'b0100, 4'b1111, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL lw got %b %b %h exp 0100 1111 deadbeef",
                              ctrl, bus.o_mem_be, bus.o_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_subword;
        logic [2:0]  f3  [6];
        logic [31:0] adr [6];
        logic [31:0] exp [6];
        drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h0000_0080);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata}
            !== {4'b0101, 4'b1000, 32'h10, 32'h8000_0000}) begin
            n_err++; $display("FAIL sb got %b %b %h %h exp 0101 1000 00000010 80000000",
                              ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata);
        end
        @(negedge clk);
        // Word at 0x10 is now 0x80ADBEEF
        f3[0] = 3'b000; adr[0] = 32'h13; exp[0] = 32'hFFFF_FF80;
        f3[1] = 3'b100; adr[1] = 32'h13; exp[1] = 32'h0000_0080;
        f3[2] = 3'b001; adr[2] = 32'h12; exp[2] = 32'hFFFF_80AD;
        f3[3] = 3'b101; adr[3] = 32'h12; exp[3] = 32'h0000_80AD;
        f3[4] = 3'b000; adr[4] = 32'h11; exp[4] = 32'hFFFF_FFBE;
        f3[5] = 3'b100; adr[5] = 32'h10; exp[5] = 32'h0000_00EF;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, f3[i], adr[i], 32'h0);
            n_vec++;
            if ({ctrl, bus.o_rsp_rdata} !== {4'b0100, exp[i]}) begin
                n_err++; $display("FAIL load_ext[%0d] f3 %b got %b %h exp 0100 %h",
                                  i, f3[i], ctrl, bus.o_rsp_rdata, exp[i]);
            end
            @(negedge clk);
        end
        drive(1'b1, 1'b1, 3'b001, 32'h16, 32'hABCD_5678);
        n_vec++;
        if ({bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata} !== {4'b1100, 32'h14, 32'h5678_0000}) begin
            n_err++; $display("FAIL sh got %b %h %h exp 1100 00000014 56780000",
                              bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        n_vec++;
        if (bus.o_rsp_rdata !== 32'h5678_0000) begin
            n_err++; $display("FAIL lw_after_sh got %h exp 56780000", bus.o_rsp_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D);
        n_vec++;
        if ({bus.o_mem_addr, bus.o_mem_be} !== {32'hFFFF_FFFC, 4'b1111}) begin
            n_err++; $display("FAIL sw_top got %h %b exp fffffffc 1111", bus.o_mem_addr, bus.o_mem_be);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        logic [2:0] bad [3];
        bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, bad[i], 32'h10, 32'hFFFF_FFFF);
            n_vec++;
            if ({ctrl, bus.o_mem_be, bus.o_rsp_rdata} !== {4'b0100, 4'b0000, 32'h0}) begin
                n_err++; $display("FAIL illegal[%0d] got %b %b %h exp 0100 0000 00000000",
                                  i, ctrl, bus.o_mem_be, bus.o_rsp_rdata);
            end
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_vec++;
        if (bus.o_rsp_rdata !== 32'h80AD_BEEF) begin
            n_err++; $display("FAIL illegal_no_write got %h exp 80adbeef", bus.o_rsp_rdata);
        end
        @(negedge clk);
    endtask

`ifndef LSU_MISALIGNED_EN
    task automatic test_misaligned;
        drive(1'b1, 1'b0, 3'b001, 32'h07, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== {4'b0010, 4'b0000}) begin
            n_err++; $display("FAIL lh_07 got %b %b exp 0010 0000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 32'h21, 32'h1122_3344);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== {4'b0010, 4'b0000}) begin
            n_err++; $display("FAIL sw_21 got %b %b exp 0010 0000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_rsp_rdata} !== {4'b0100, 32'h0}) begin
            n_err++; $display("FAIL sw_21_not_written got %b %h exp 0100 0", ctrl, bus.o_rsp_rdata);
        end
        @(negedge clk);
        // Half at offset 2 ends exactly on the word boundary: not crossing
        drive(1'b1, 1'b0, 3'b101, 32'hFFFF_FFFE, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_rsp_rdata} !== {4'b0100, 4'b1100, 32'h0000_CAFE}) begin
            n_err++; $display("FAIL lhu_edge got %b %b %h exp 0100 1100 0000cafe",
                              ctrl, bus.o_mem_be, bus.o_rsp_rdata);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_split;
        drive(1'b1, 1'b1, 3'b010, 32'h21, 32'h1122_3344);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata}
            !== {4'b1001, 4'b1110, 32'h20, 32'h2233_4400}) begin
            n_err++; $display("FAIL sw_split1 got %b %b %h %h exp 1001 1110 00000020 22334400",
                              ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata);
        end
        @(negedge clk);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata}
            !== {4'b0101, 4'b0001, 32'h24, 32'h0000_0011}) begin
            n_err++; $display("FAIL sw_split2 got %b %b %h %h exp 0101 0001 00000024 00000011",
                              ctrl, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
        n_vec++;
        if (ctrl !== 4'b1000) begin
            n_err++; $display("FAIL lw_split1 got %b exp 1000", ctrl);
        end
        @(negedge clk);
        n_vec++;
        if ({ctrl, bus.o_rsp_rdata} !== {4'b0100, 32'h1122_3344}) begin
            n_err++; $display("FAIL lw_split2 got %b %h exp 0100 11223344", ctrl, bus.o_rsp_rdata);
        end
        @(negedge clk);
        // Back-to-back crossing halfword
        drive(1'b1, 1'b0, 3'b001, 32'h23, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== {4'b1000, 4'b1000}) begin
            n_err++; $display("FAIL lh_split1 got %b %b exp 1000 1000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
        n_vec++;
        if ({ctrl, bus.o_mem_be, bus.o_rsp_rdata} !== {4'b0100, 4'b0001, 32'h0000_1122}) begin
            n_err++; $display("FAIL lh_split2 got %b %b %h exp 0100 0001 00001122",
                              ctrl, bus.o_mem_be, bus.o_rsp_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        n_vec++;
        if (bus.o_mem_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap1 got %h exp fffffffc", bus.o_mem_addr);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.o_mem_addr, bus.o_rsp_rdata} !== {32'h0, 32'h0000_CAFE}) begin
            n_err++; $display("FAIL wrap2 got %h %h exp 00000000 0000cafe",
                              bus.o_mem_addr, bus.o_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        // Flush in SECOND
        drive(1'b1, 1'b1, 3'b010, 32'h31, 32'hAABB_CCDD);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h31, 32'hAABB_CCDD);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== 8'h00) begin
            n_err++; $display("FAIL flush got %b %b exp 0000 0000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h34, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_rsp_rdata} !== {4'b0100, 32'h0}) begin
            n_err++; $display("FAIL flush_no_second got %b %h exp 0100 0", ctrl, bus.o_rsp_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        n_vec++;
        if (bus.o_rsp_rdata !== 32'hBBCC_DD00) begin
            n_err++; $display("FAIL flush_first_kept got %h exp bbccdd00", bus.o_rsp_rdata);
        end
        @(negedge clk);
        // Reset in SECOND
        drive(1'b1, 1'b1, 3'b010, 32'h42, 32'h5566_7788);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== 8'h00) begin
            n_err++; $display("FAIL rst_second got %b %b exp 0000 0000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
        n_vec++;
        if ({ctrl, bus.o_rsp_rdata} !== {4'b0100, 32'h0}) begin
            n_err++; $display("FAIL rst_no_second got %b %h exp 0100 0", ctrl, bus.o_rsp_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        n_vec++;
        if (bus.o_rsp_rdata !== 32'h7788_0000) begin
            n_err++; $display("FAIL rst_first_kept got %h exp 77880000", bus.o_rsp_rdata);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_idle;
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
        n_vec++;
        if ({ctrl, bus.o_mem_be} !== 8'h00) begin
            n_err++; $display("FAIL idle got %b %b exp 0000 0000", ctrl, bus.o_mem_be);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        mem_clr = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        test_reset();
        test_word();
        test_subword();
        test_illegal();
`ifndef LSU_MISALIGNED_EN
        test_misaligned();
`else
        test_split();
        test_abort();
`endif
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MEM stage of the pipelined RISC-V core, sitting directly upstream of `data_mem`. It turns a decoded load/store request into the word address, byte-enable mask and lane-aligned write data that `data_mem` consumes. It converts the returned word into a sign- or zero-extended load result. Accesses that cross a word boundary are split into two back-to-back memory cycles by a small FSM, which stalls the pipeline for one cycle.

## Interface
- none — XLEN fixed at 32; memory word is 32 bits, byte-addressed
- `i_clk` in 1 — core clock
- `i_rst` in 1 — synchronous, active-high reset
- `i_req_valid` in 1 — MEM stage holds a load/store
- `i_req_we` in 1 — 1 = store, 0 = load
- `i_req_funct3` in 3 — 000 B, 001 H, 010 W, 100 BU, 101 HU
- `i_req_addr` in 32 — byte address
- `i_req_wdata` in 32 — store data, LSB-justified
- `o_busy` out 1 — stall MEM and everything upstream
- `o_rsp_valid` out 1 — access complete this cycle
- `o_rsp_rdata` out 32 — extended load result; 0 for stores
- `o_misaligned` out 1 — misaligned-access exception (only without `LSU_MISALIGNED_EN`)
- `o_mem_we` out 1 — to `data_mem` `i_write_en`
- `o_mem_addr` out 32 — to `data_mem` `i_addr`, bits [1:0] always 00
- `o_mem_wdata` out 32 — to `data_mem` `i_write_data`, lane-shifted
- `o_mem_be` out 4 — to `data_mem` `i_byte_en`
- `i_mem_rdata` in 32 — from `data_mem` `o_read_data`, asynchronous read

## Operation
- Size: B=1, H=2, W=4 bytes. Offset `off` = `addr[1:0]`. The access crosses a word boundary when `off` + size > 4, i.e. H at off 3 or W at off 1–3.
- Aligned (non-crossing) access:
  - One cycle; `o_mem_addr` = {addr[31:2],00}.
  - `o_mem_be` = ((1<<size)−1) << off.
  - `o_mem_wdata` = wdata << (8·off).
  - Load result = `i_mem_rdata` >> (8·off), truncated to size, then sign-extended (B/H) or zero-extended (BU/HU).
- FSM states: IDLE, SECOND.
- IDLE, crossing request:
  - First access uses word A = {addr[31:2],00}, with `o_mem_be` = lanes off..3 and `o_mem_wdata` = wdata << (8·off).
  - `o_busy`=1 and `o_rsp_valid`=0.
  - On a load, latch `i_mem_rdata` >> (8·off) into the low-part register. Then go to SECOND.
- SECOND:
  - Access A+4, computed modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - n1 = 4−off. `o_mem_be` = lanes 0..(size−n1−1). `o_mem_wdata` = wdata >> (8·n1).
  - Load result = low | (`i_mem_rdata` << (8·n1)), then truncated and extended.
  - `o_busy`=0, `o_rsp_valid`=1; return to IDLE.
- `i_req_valid`=0 in SECOND (flush): abort and return to IDLE. No second write is performed and `o_rsp_valid`=0. A first-half store is already committed and is not rolled back.
- Illegal funct3 (011, 110, 111):
  - No memory write; `o_rsp_valid`=1, `o_rsp_rdata`=0.
  - Decode never issues these; the behaviour is defined only for determinism.
- `o_mem_we` = `i_req_valid` & `i_req_we` & (legal access). It is never asserted while `i_rst`=1.
- The upstream stage holds all `i_req_*` stable while `o_busy`=1.

## Timing
- Reset values while `i_rst`=1, and the cycle after reset:
  - state IDLE, low-part register 0.
  - `o_busy`, `o_rsp_valid`, `o_misaligned` and `o_mem_we` are all 0.
  - `o_mem_be`=0000, `o_mem_addr`=0, `o_mem_wdata`=0, `o_rsp_rdata`=0.
- Aligned access: zero-cycle latency. All outputs are combinational from the request and `i_mem_rdata`; a store is written on the next `i_clk` edge.
- Crossing access: two cycles, with `o_busy` high in the first only.
- Reset in SECOND: return to IDLE on that edge; no second access.
- Back-to-back requests: a new request is accepted in IDLE on the cycle immediately after SECOND completes.

## Configuration
- `LSU_MISALIGNED_EN` defined: crossing accesses are split as above and `o_misaligned` is tied to 0.
- `LSU_MISALIGNED_EN` undefined:
  - The FSM and low-part register are not compiled.
  - A crossing request gives `o_misaligned`=1 in the same cycle, with `o_mem_we`=0, `o_mem_be`=0000, `o_rsp_valid`=0 and `o_busy`=0.
  - Aligned accesses are unchanged.

## Structure
- `lsu_pkg` holds:
  - the `ls_size_e` encodings matching funct3 (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - the `lsu_state_e` enum (IDLE, SECOND);
  - the localparams `LSU_WORD_BYTES`=4 and `LSU_XLEN`=32.
- One sub-module, `lsu_load_ext`: combinational truncate-and-extend of a right-justified 32-bit value by funct3. It is shared by the aligned and split paths.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `o_mem_be`=1111, `o_rsp_rdata`=0xDEADBEEF, `o_busy` never high.
- SB 0x80 @0x13, then LB @0x13 → `o_mem_be`=1000, `o_mem_wdata`=0x80000000, LB=0xFFFFFF80, LBU=0x00000080.
- With `LSU_MISALIGNED_EN`, SW 0x11223344 @0x21:
  - cycle 1: `o_busy`=1, addr 0x20, be 1110;
  - cycle 2: addr 0x24, be 0001;
  - a following LW @0x21 returns 0x11223344.
- Without `LSU_MISALIGNED_EN`, LH @0x07 → `o_misaligned`=1, `o_mem_we`=0, `o_rsp_valid`=0.
- Split LW @0xFFFFFFFE → second access addr 0x00000000. `i_rst` or `i_req_valid`=0 asserted in SECOND → no second write, state IDLE next cycle.
- Illegal funct3 011 store → `o_mem_we`=0, `o_rsp_valid`=1, `o_rsp_rdata`=0.
